// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, answers after WAIT_CYCLES wait states.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned half/word accesses instead of masking them.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          misalign;
  logic [31:0]   rd_word, wr_word, ld_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          mem_we;

  // Address bits above the memory size wrap and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign idx = addr_q[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
  assign off      = addr_q[1:0];
`else
  assign misalign = 1'b0;
  always_comb begin
    unique case (size_q)
      2'b00:   off = addr_q[1:0];
      2'b01:   off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
  end
`endif

  assign rd_word = mem_q[idx];

  always_comb begin
    byte_sel = 8'h00;
    unique case (off)
      2'b00: byte_sel = rd_word[31:24];
      2'b01: byte_sel = rd_word[23:16];
      2'b10: byte_sel = rd_word[15:8];
      2'b11: byte_sel = rd_word[7:0];
    endcase
    half_sel = off[1] ? rd_word[15:0] : rd_word[31:16];

    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_data = rd_word;
    endcase

    // Read-modify-write keeps the untouched lanes intact.
    wr_word = rd_word;
    case (size_q)
      2'b00: begin
        unique case (off)
          2'b00: wr_word[31:24] = wdata_q[7:0];
          2'b01: wr_word[23:16] = wdata_q[7:0];
          2'b10: wr_word[15:8]  = wdata_q[7:0];
          2'b11: wr_word[7:0]   = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) wr_word[15:0] = wdata_q[15:0];
        else        wr_word[31:16] = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  assign mem_we = (state_q == StResp) && write_q && !misalign && !rst;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) state_d = StResp;
        cnt_d = cnt_q - 4'd1;
      end
      StResp: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = (write_q || misalign) ? 32'h0 : ld_data;
        resp_err_d   = misalign;
        cnt_d        = 4'd0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign stall      = req_valid && !resp_valid_q;

endmodule
